spi_master_core: RTL and testbench
==================================

Name: spi_master_core

Overview:
- Single-clock SPI master with an 8-bit shift engine and a receive FIFO.
- Supports SPI modes 0-3, a selectable SCLK divider, MSB-first or LSB-first order, and decoded selection of one of 4 slaves.
- Every received byte goes to o_parallel_out and is pushed into the RX FIFO, which the host drains with i_read_enable.
- Sits between a host-side register/control block and the external SPI pins.

Parameters:
- FIFO_DEPTH, 16, RX FIFO depth in bytes (power of 2).
- RST_BUSY_CYCLES, 4, number of cycles o_rst_busy stays high after reset is released.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_DV  in  1  transfer request; rising edge starts one transfer.
- i_parallel_in  in  8  byte to transmit, latched on the accepted request.
- i_rate  in  2  SCLK period = 2^(i_rate+1) i_clk cycles (2/4/8/16).
- i_MISO  in  1  serial data from slave.
- i_SS  in  2  index of the slave to select.
- i_mode  in  2  SPI mode; bit1 = CPOL, bit0 = CPHA.
- i_MSB  in  1  1 = MSB first, 0 = LSB first (applies to both TX and RX).
- i_read_enable  in  1  RX FIFO pop strobe.
- o_SS  out  4  active-low one-hot slave selects.
- o_MOSI  out  1  serial data to slave.
- o_sckl  out  1  SPI clock.
- o_parallel_out  out  8  last received byte.
- o_done  out  1  level; transfer complete.
- o_fifo_out  out  8  byte popped from RX FIFO.
- o_rst_busy  out  1  high while post-reset init runs.
- o_rx_empty  out  1  RX FIFO empty.

Behaviour:
- Reset (i_reset=1): all state is cleared.
  - o_SS=4'b1111, o_MOSI=0, o_sckl=CPOL, o_parallel_out=0, o_done=0, o_fifo_out=0, o_rx_empty=1, o_rst_busy=1, FIFO pointers and count = 0.
- After reset is released, o_rst_busy stays high for RST_BUSY_CYCLES cycles, then drops to 0.
- While o_rst_busy=1, i_DV and i_read_enable are ignored.
- State machine: IDLE -> TRANSFER -> DONE -> IDLE.
- IDLE:
  - o_sckl tracks CPOL.
  - A rising edge of i_DV (registered previous value 0, current value 1) with o_rst_busy=0 is accepted.
  - On acceptance: latch i_parallel_in, i_mode, i_rate, i_MSB and i_SS; clear o_done.
  - Next cycle: o_SS[i_SS] goes low.
  - Holding i_DV high for several cycles starts exactly one transfer.
- TRANSFER:
  - 8 SCLK periods; each half-period lasts 2^i_rate i_clk cycles. 16 edges in total, then o_sckl returns to CPOL.
  - CPHA=0: the first bit is on MOSI when SS asserts. MISO is sampled on leading edges; MOSI shifts on trailing edges.
  - CPHA=1: MOSI updates on leading edges; MISO is sampled on trailing edges.
  - Bit order: i_MSB=0 sends bit0 first and the first received bit lands in rx[0]. i_MSB=1 sends bit7 first and the first received bit lands in rx[7].
- DONE (1 cycle):
  - Deassert all SS; o_MOSI goes to 0.
  - o_parallel_out <= received byte; o_done <= 1.
  - Push the byte into the FIFO if it is not full. If full, the byte is dropped; o_parallel_out still updates.
- o_done stays high until the next accepted request.
- A new request is accepted only in IDLE; a request during TRANSFER is ignored.
- Input changes during a transfer have no effect, because all configuration is latched.
- RX FIFO:
  - Pop on i_read_enable while not empty; o_fifo_out is registered one cycle after the pop.
  - o_fifo_out holds its value when there is no pop.
  - Pop on empty is ignored.
  - A simultaneous push and pop are both performed and the count is unchanged.
  - o_rx_empty is derived combinationally from the count; it deasserts the cycle after the push.
- Reset mid-transfer: the transfer aborts immediately, SS deasserts, nothing is pushed, and the FIFO is cleared.

Decomposition:
- Shared package holds:
  - mode constants (MODE0..MODE3);
  - state enum (IDLE/TRANSFER/DONE);
  - the rate-to-half-period function.
- One sub-module, spi_rx_fifo: synchronous FIFO with push/pop/empty/full/count and a registered output.

Test Plan:
- Reset release: reset high 1 cycle, then low -> o_rst_busy=1 for 4 cycles, then 0; o_SS=4'hF, o_rx_empty=1, o_done=0.
- Mode 0, LSB-first, rate 2, i_SS=0, 0xAA, MISO=1, i_DV held 2 cycles -> one transfer only.
  - o_SS=4'b1110 during the transfer.
  - MOSI=0,1,0,1,0,1,0,1; SCLK period 8 clocks, 64 clocks total.
  - o_parallel_out=0xFF; o_done stays high.
- FIFO pop after that transfer: wait o_rx_empty=0, pulse i_read_enable 1 cycle -> o_fifo_out=0xFF next cycle; o_rx_empty=1.
- Mode 3, MSB-first, rate 0, i_SS=3, 0x3C, slave loops MOSI back to MISO.
  - o_sckl idles high; o_SS=4'b0111.
  - o_parallel_out=0x3C.
- Fill 16 bytes, then a 17th transfer -> count stays 16, 17th byte dropped; pops return the first 16 in order.
- Reset asserted mid-transfer -> SS=4'hF next cycle; o_rx_empty=1; o_done=0; o_rst_busy pulses again.

Source files
------------

// File: rtl/spi_master_core_pkg.sv
// rtl/spi_master_core_pkg.sv - shared SPI master definitions
// Contents: SPI mode encodings, controller state enum, SCLK half-period
// lookup and serial bit-order helpers used by the shift engine.
package spi_master_core_pkg;

    // Mode encoding: bit1 = CPOL, bit0 = CPHA
    localparam logic [1:0] MODE0 = 2'd0;
    localparam logic [1:0] MODE1 = 2'd1;
    localparam logic [1:0] MODE2 = 2'd2;
    localparam logic [1:0] MODE3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRANSFER = 2'd1,
        DONE     = 2'd2
    } state_t;

    // Number of i_clk cycles per SCLK half-period: 1, 2, 4 or 8
    function automatic logic [3:0] half_period(input logic [1:0] rate);
        return 4'd1 << rate;
    endfunction

    // Bit that goes on the wire next, given the bit order
    function automatic logic tx_bit(input logic [7:0] data, input logic msb_first);
        return msb_first ? data[7] : data[0];
    endfunction

    // Remaining bits after tx_bit has been sent
    function automatic logic [7:0] tx_shift(input logic [7:0] data, input logic msb_first);
        return msb_first ? {data[6:0], 1'b0} : {1'b0, data[7:1]};
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - synchronous receive FIFO with registered read data
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_push, i_push_data   write strobe and byte (ignored when full)
//   i_pop                 read strobe (ignored when empty)
//   o_pop_data            popped byte, valid the cycle after i_pop, held otherwise
//   o_empty, o_full       occupancy flags decoded from the count
module spi_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_pop_data;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_pop_data = r_pop_data;
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;

    // Storage is not reset; only pointers and count define its contents
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pop_data <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_pop_data <= r_mem[r_rd_ptr];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// rtl/spi_master_core.sv - SPI master: 8-bit shift engine plus RX FIFO
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_DV                 transfer request (rising edge accepted in IDLE)
//   i_parallel_in        byte to send; i_rate / i_mode / i_MSB / i_SS config
//   i_MISO               serial input from slave
//   i_read_enable        RX FIFO pop strobe
//   o_SS, o_MOSI, o_sckl SPI pins (selects active-low one-hot)
//   o_parallel_out       last received byte; o_done level until next request
//   o_fifo_out           byte popped from the RX FIFO
//   o_rst_busy           post-reset init in progress
//   o_rx_empty           RX FIFO empty
module spi_master_core
    import spi_master_core_pkg::*;
#(
    parameter int FIFO_DEPTH      = 16,
    parameter int RST_BUSY_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_DV,
    input  logic [7:0] i_parallel_in,
    input  logic [1:0] i_rate,
    input  logic       i_MISO,
    input  logic [1:0] i_SS,
    input  logic [1:0] i_mode,
    input  logic       i_MSB,
    input  logic       i_read_enable,
    output logic [3:0] o_SS,
    output logic       o_MOSI,
    output logic       o_sckl,
    output logic [7:0] o_parallel_out,
    output logic       o_done,
    output logic [7:0] o_fifo_out,
    output logic       o_rst_busy,
    output logic       o_rx_empty
);

    localparam int BW = (RST_BUSY_CYCLES < 1) ? 1 : $clog2(RST_BUSY_CYCLES + 1);

    state_t      r_state;
    state_t      w_next_state;

    logic [BW-1:0] r_busy_cnt;
    logic        r_dv_prev;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx;
    logic        r_cpha;
    logic [1:0]  r_rate;
    logic        r_msb;
    logic [2:0]  r_half_cnt;
    logic [3:0]  r_edge_cnt;
    logic        r_sclk;
    logic        r_mosi;
    logic [3:0]  r_ss;
    logic [7:0]  r_par_out;
    logic        r_done;

    logic        w_busy;
    logic        w_accept;
    logic [3:0]  w_half_len;
    logic        w_half_last;
    logic        w_edge;
    logic        w_leading;
    logic        w_trailing;
    logic        w_drive;
    logic        w_sample;
    logic        w_last_edge;
    logic        w_rx_full;
    logic        w_push;

    assign w_busy      = (r_busy_cnt != '0);
    assign w_accept    = (r_state == IDLE) && i_DV && !r_dv_prev && !w_busy;
    assign w_half_len  = half_period(r_rate);
    assign w_half_last = ({1'b0, r_half_cnt} == (w_half_len - 4'd1));
    assign w_edge      = (r_state == TRANSFER) && w_half_last;
    // Even edge numbers are leading edges (away from CPOL), odd are trailing
    assign w_leading   = w_edge && !r_edge_cnt[0];
    assign w_trailing  = w_edge && r_edge_cnt[0];
    assign w_drive     = r_cpha ? w_leading : w_trailing;
    assign w_sample    = r_cpha ? w_trailing : w_leading;
    assign w_last_edge = w_edge && (r_edge_cnt == 4'd15);
    assign w_push      = (r_state == DONE) && !w_rx_full;

    assign o_SS           = r_ss;
    assign o_MOSI         = r_mosi;
    assign o_sckl         = r_sclk;
    assign o_parallel_out = r_par_out;
    assign o_done         = r_done;
    assign o_rst_busy     = w_busy;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_next_state = TRANSFER;
            TRANSFER: if (w_last_edge) w_next_state = DONE;
            DONE:     w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy_cnt <= BW'(RST_BUSY_CYCLES);
            r_dv_prev  <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_cpha     <= 1'b0;
            r_rate     <= '0;
            r_msb      <= 1'b0;
            r_half_cnt <= '0;
            r_edge_cnt <= '0;
            r_sclk     <= i_mode[1];
            r_mosi     <= 1'b0;
            r_ss       <= 4'hF;
            r_par_out  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_dv_prev <= i_DV;
            if (w_busy) begin
                r_busy_cnt <= r_busy_cnt - BW'(1);
            end

            case (r_state)
                IDLE: begin
                    // SCLK follows the live CPOL while idle; once a transfer
                    // starts it toggles from that latched level, so no
                    // separate CPOL register is needed.
                    r_sclk     <= i_mode[1];
                    r_half_cnt <= '0;
                    r_edge_cnt <= '0;
                    if (w_accept) begin
                        r_cpha <= i_mode[0];
                        r_rate <= i_rate;
                        r_msb  <= i_MSB;
                        r_ss   <= ~(4'b0001 << i_SS);
                        r_done <= 1'b0;
                        r_rx   <= '0;
                        if (!i_mode[0]) begin
                            // CPHA=0: first bit must be valid before the first edge
                            r_mosi <= tx_bit(i_parallel_in, i_MSB);
                            r_tx   <= tx_shift(i_parallel_in, i_MSB);
                        end else begin
                            r_mosi <= 1'b0;
                            r_tx   <= i_parallel_in;
                        end
                    end
                end

                TRANSFER: begin
                    if (w_half_last) begin
                        r_half_cnt <= '0;
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= r_edge_cnt + 4'd1;
                    end else begin
                        r_half_cnt <= r_half_cnt + 3'd1;
                    end
                    if (w_drive) begin
                        r_mosi <= tx_bit(r_tx, r_msb);
                        r_tx   <= tx_shift(r_tx, r_msb);
                    end
                    if (w_sample) begin
                        r_rx <= r_msb ? {r_rx[6:0], i_MISO} : {i_MISO, r_rx[7:1]};
                    end
                end

                DONE: begin
                    r_ss      <= 4'hF;
                    r_mosi    <= 1'b0;
                    r_par_out <= r_rx;
                    r_done    <= 1'b1;
                end

                default: begin
                    r_ss <= 4'hF;
                end
            endcase
        end
    end

    spi_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_push_data (r_rx),
        .i_pop       (i_read_enable && !w_busy),
        .o_pop_data  (o_fifo_out),
        .o_empty     (o_rx_empty),
        .o_full      (w_rx_full)
    );

endmodule

// File: tb/tb_spi_master_core.sv
// tb/tb_spi_master_core.sv - directed self-checking bench for spi_master_core
module tb_spi_master_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       dv;
    logic [7:0] parallel_in;
    logic [1:0] rate;
    logic       miso;
    logic [1:0] ss_idx;
    logic [1:0] mode;
    logic       msb;
    logic       read_enable;
    logic [3:0] ss_n;
    logic       mosi;
    logic       sckl;
    logic [7:0] parallel_out;
    logic       done;
    logic [7:0] fifo_out;
    logic       rst_busy;
    logic       rx_empty;

    logic       loopback;
    logic       miso_val;
    logic [7:0] tx_byte;

    int n_checks = 0;
    int n_errors = 0;

    assign miso = loopback ? mosi : miso_val;

    always #5 clk = ~clk;

    spi_master_core #(
        .FIFO_DEPTH      (16),
        .RST_BUSY_CYCLES (4)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_DV           (dv),
        .i_parallel_in  (parallel_in),
        .i_rate         (rate),
        .i_MISO         (miso),
        .i_SS           (ss_idx),
        .i_mode         (mode),
        .i_MSB          (msb),
        .i_read_enable  (read_enable),
        .o_SS           (ss_n),
        .o_MOSI         (mosi),
        .o_sckl         (sckl),
        .o_parallel_out (parallel_out),
        .o_done         (done),
        .o_fifo_out     (fifo_out),
        .o_rst_busy     (rst_busy),
        .o_rx_empty     (rx_empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [7:0] data, input logic [1:0] m, input logic [1:0] r,
                         input logic order, input logic [1:0] s);
        parallel_in = data;
        mode        = m;
        rate        = r;
        msb         = order;
        ss_idx      = s;
        dv          = 1'b1;
        tick();
        dv          = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check(tag, done, 1'b1);
    endtask

    initial begin
        reset       = 1'b1;
        dv          = 1'b0;
        parallel_in = 8'h00;
        rate        = 2'd0;
        ss_idx      = 2'd0;
        mode        = 2'd0;
        msb         = 1'b0;
        read_enable = 1'b0;
        loopback    = 1'b0;
        miso_val    = 1'b1;

        // Reset: one cycle high, then release
        tick();
        reset = 1'b0;
        check("rst_ss", ss_n, 4'hF);
        check("rst_mosi", mosi, 1'b0);
        check("rst_sclk", sckl, 1'b0);
        check("rst_par", parallel_out, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_fifo_out", fifo_out, 8'h00);
        check("rst_empty", rx_empty, 1'b1);
        check("busy_0", rst_busy, 1'b1);
        // A request while busy must be ignored
        dv = 1'b1;
        tick();
        check("busy_1", rst_busy, 1'b1);
        dv = 1'b0;
        tick();
        check("busy_2", rst_busy, 1'b1);
        tick();
        check("busy_3", rst_busy, 1'b1);
        tick();
        check("busy_end", rst_busy, 1'b0);
        check("busy_dv_ignored_ss", ss_n, 4'hF);
        tick();
        check("busy_dv_ignored_ss2", ss_n, 4'hF);

        // Mode 0, LSB first, rate 2, slave 0, 0xAA, MISO=1, DV held 2 cycles
        tx_byte     = 8'hAA;
        parallel_in = tx_byte;
        mode        = 2'd0;
        rate        = 2'd2;
        msb         = 1'b0;
        ss_idx      = 2'd0;
        dv          = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("m0_mosi_b%0d", k), mosi, tx_byte[k]);
            check($sformatf("m0_ss_b%0d", k), ss_n, 4'b1110);
            check($sformatf("m0_sclk_lo_b%0d", k), sckl, 1'b0);
            check($sformatf("m0_done_lo_b%0d", k), done, 1'b0);
            tick();
            if (k == 0) dv = 1'b0;
            repeat (3) tick();
            check($sformatf("m0_sclk_hi_b%0d", k), sckl, 1'b1);
            repeat (4) tick();
        end
        check("m0_sclk_end", sckl, 1'b0);
        check("m0_ss_end", ss_n, 4'b1110);
        tick();
        check("m0_done", done, 1'b1);
        check("m0_par", parallel_out, 8'hFF);
        check("m0_ss_off", ss_n, 4'hF);
        check("m0_mosi_off", mosi, 1'b0);
        check("m0_not_empty", rx_empty, 1'b0);
        repeat (10) tick();
        check("m0_single_xfer_ss", ss_n, 4'hF);
        check("m0_done_held", done, 1'b1);

        // Pop the received byte
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        check("pop0_data", fifo_out, 8'hFF);
        check("pop0_empty", rx_empty, 1'b1);

        // Mode 3, MSB first, rate 0, slave 3, loopback, inputs changed mid-transfer
        loopback = 1'b1;
        mode     = 2'd3;
        tick();
        check("m3_sclk_idle", sckl, 1'b1);
        start(8'h3C, 2'd3, 2'd0, 1'b1, 2'd3);
        check("m3_ss", ss_n, 4'b0111);
        check("m3_done_clr", done, 1'b0);
        parallel_in = 8'h00;
        mode        = 2'd0;
        msb         = 1'b0;
        ss_idx      = 2'd1;
        tick();
        check("m3_ss_mid", ss_n, 4'b0111);
        wait_done("m3_wait");
        check("m3_par", parallel_out, 8'h3C);
        check("m3_ss_off", ss_n, 4'hF);

        // Pop it, then pop on empty must be ignored
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        check("pop1_data", fifo_out, 8'h3C);
        check("pop1_empty", rx_empty, 1'b1);
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        check("pop_empty_hold", fifo_out, 8'h3C);
        check("pop_empty_still", rx_empty, 1'b1);

        // Fill 16 and send a 17th that must be dropped
        for (int i = 0; i < 17; i++) begin
            start(8'h10 + 8'(i), 2'd0, 2'd0, 1'b1, 2'd1);
            wait_done($sformatf("fill_wait_%0d", i));
        end
        check("fill_par_17th", parallel_out, 8'h20);
        read_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("fill_pop_%0d", i), fifo_out, 8'h10 + 8'(i));
        end
        read_enable = 1'b0;
        check("fill_drained", rx_empty, 1'b1);

        // Reset in the middle of a transfer
        start(8'h5A, 2'd1, 2'd3, 1'b0, 2'd2);
        wait_done("m1_wait");
        check("m1_par", parallel_out, 8'h5A);
        check("m1_not_empty", rx_empty, 1'b0);
        start(8'h99, 2'd1, 2'd3, 1'b0, 2'd2);
        repeat (20) tick();
        check("abort_ss_active", ss_n, 4'b1011);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ss", ss_n, 4'hF);
        check("abort_empty", rx_empty, 1'b1);
        check("abort_done", done, 1'b0);
        check("abort_par", parallel_out, 8'h00);
        check("abort_busy_0", rst_busy, 1'b1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("abort_busy_%0d", i), rst_busy, 1'b1);
        end
        tick();
        check("abort_busy_end", rst_busy, 1'b0);
        repeat (150) tick();
        check("abort_no_push", rx_empty, 1'b1);
        check("abort_ss_idle", ss_n, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
